// File: rtl/data_mem_pkg.sv
// Shared types and widths for the data memory load/store front-end.
package data_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 2;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge (little-endian).
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    input  mem_size_e         size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] new_data,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] merge_data_c
);

    logic [DATA_W-1:0] shifted;
    logic              sign_b;
    logic              sign_h;

    always_comb begin
        shifted      = word >> {offset, 3'b000};
        sign_b       = ~is_unsigned & shifted[7];
        sign_h       = ~is_unsigned & shifted[15];
        load_data_c  = word;
        merge_data_c = new_data;
        case (size)
            BYTE: begin
                load_data_c  = {{24{sign_b}}, shifted[7:0]};
                merge_data_c = word;
                merge_data_c[{offset, 3'b000} +: 8] = new_data[7:0];
            end
            HALF: begin
                load_data_c  = {{16{sign_h}}, shifted[15:0]};
                merge_data_c = word;
                merge_data_c[{offset[1], 4'b0000} +: 16] = new_data[15:0];
            end
            default: begin
                load_data_c  = word;
                merge_data_c = new_data;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller in front of a word-addressed RAM; sub-word stores use read-modify-write.
// Optional misalignment error reporting: define DATA_MEM_MISALIGN_CHECK_EN.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                ram_wen,
    output logic                ram_ren,
    output logic [ADDR_W-3:0]   ram_waddr,
    output logic [ADDR_W-3:0]   ram_raddr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    mem_state_e        state_q, state_d;
    logic              we_q;
    mem_size_e         size_q;
    logic              unsigned_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] wdata_q;

    mem_size_e         size_in;
    logic [OFF_W-1:0]  off_in;
    logic              accept;
    logic              ready_d, ren_d, wen_d, rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d, ram_wdata_d;
    logic [DATA_W-1:0] load_data_c, merge_data_c;

    mem_lane_align u_align (
        .word         (ram_rdata),
        .offset       (off_q),
        .size         (size_q),
        .is_unsigned  (unsigned_q),
        .new_data     (wdata_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Size 11 behaves as word; low offset bits are forced to natural alignment.
    always_comb begin
        size_in = (req_size == 2'b11) ? WORD : mem_size_e'(req_size);
        off_in  = req_addr[1:0];
        if (size_in == HALF) off_in[0] = 1'b0;
        if (size_in == WORD) off_in = 2'b00;
        accept  = req_valid & req_ready;
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        ren_d       = 1'b0;
        wen_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        ram_wdata_d = ram_wdata;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
                    if ((size_in == HALF && req_addr[0]) ||
                        (size_in == WORD && req_addr[1:0] != 2'b00)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else
`endif
                    if (!req_we || size_in != WORD) begin
                        state_d = ST_RD_ADDR;
                        ren_d   = 1'b1;
                    end else begin
                        state_d     = ST_WRITE;
                        wen_d       = 1'b1;
                        ram_wdata_d = req_wdata;
                    end
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_DATA;
                ren_d   = 1'b1;
            end
            // RAM data is sampled at the end of RD_DATA for both load and RMW.
            ST_RD_DATA: begin
                if (we_q) begin
                    state_d     = ST_WRITE;
                    wen_d       = 1'b1;
                    ram_wdata_d = merge_data_c;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data_c;
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            ram_wen    <= 1'b0;
            ram_ren    <= 1'b0;
            ram_waddr  <= '0;
            ram_raddr  <= '0;
            ram_wdata  <= '0;
            we_q       <= 1'b0;
            size_q     <= BYTE;
            unsigned_q <= 1'b0;
            off_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            ram_wen   <= wen_d;
            ram_ren   <= ren_d;
            ram_wdata <= ram_wdata_d;
            if (accept) begin
                we_q       <= req_we;
                size_q     <= size_in;
                unsigned_q <= req_unsigned;
                off_q      <= off_in;
                wdata_q    <= req_wdata;
                ram_waddr  <= req_addr[ADDR_W-1:2];
                ram_raddr  <= req_addr[ADDR_W-1:2];
            end
        end
    end

endmodule
